// File: rtl/inst_fetch_queue.sv
// Instruction fetch unit: one outstanding memory request at a time,
// returned instructions buffered with their PCs in a FIFO toward decode.
module inst_fetch_queue #(
    parameter int                 ADDR_W     = 32,
    parameter int                 INST_W     = 32,
    parameter int                 DEPTH_LOG  = 3,
    parameter logic [ADDR_W-1:0]  START_ADDR = '0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    output logic              IF_MC_ask,
    output logic [ADDR_W-1:0] IF_MC_Addr,
    input  logic              MC_IF_ok,
    input  logic              MC_IF_arrive,
    input  logic [INST_W-1:0] MC_IF_Inst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              IF_ID_valid,
    output logic [INST_W-1:0] IF_ID_Inst,
    output logic [ADDR_W-1:0] IF_ID_PC,
    input  logic              ID_IF_ready
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam int PTR_W = (DEPTH_LOG > 0) ? DEPTH_LOG : 1;
    localparam int CNT_W = DEPTH_LOG + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASK,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              ask_q, ask_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              head_valid_q, head_valid_d;
    logic [INST_W-1:0] head_inst_q, head_inst_d;
    logic [ADDR_W-1:0] head_pc_q, head_pc_d;

    logic [INST_W-1:0] mem_inst_q [DEPTH];
    logic [ADDR_W-1:0] mem_pc_q   [DEPTH];

    logic push;
    logic pop;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        ask_d        = ask_q;
        addr_d       = addr_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        head_valid_d = head_valid_q;
        head_inst_d  = head_inst_q;
        head_pc_d    = head_pc_q;
        push         = 1'b0;
        pop          = 1'b0;

        if (rdy_in) begin
            pop = head_valid_q && ID_IF_ready && !redirect_valid;

            unique case (state_q)
                S_IDLE: begin
                    if (!redirect_valid && count_q < DEPTH_C) begin
                        state_d = S_ASK;
                        ask_d   = 1'b1;
                        addr_d  = fetch_pc_q;
                    end
                end
                S_ASK: begin
                    if (MC_IF_ok) begin
                        ask_d   = 1'b0;
                        state_d = redirect_valid ? S_DISCARD : S_WAIT;
                    end else if (redirect_valid) begin
                        ask_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (MC_IF_arrive) begin
                        state_d = S_IDLE;
                        if (!redirect_valid) begin
                            push       = 1'b1;
                            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                        end
                    end else if (redirect_valid) begin
                        state_d = S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (MC_IF_arrive) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (redirect_valid) begin
                fetch_pc_d = redirect_pc;
                wr_ptr_d   = '0;
                rd_ptr_d   = '0;
                count_d    = '0;
            end else begin
                if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
                count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            end

            // Head register tracks the entry at the next read pointer,
            // bypassing the write when that slot is being filled now.
            head_valid_d = (count_d != '0);
            if (count_d == '0) begin
                head_inst_d = '0;
                head_pc_d   = '0;
            end else if (push && wr_ptr_q == rd_ptr_d) begin
                head_inst_d = MC_IF_Inst;
                head_pc_d   = fetch_pc_q;
            end else begin
                head_inst_d = mem_inst_q[rd_ptr_d];
                head_pc_d   = mem_pc_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= S_IDLE;
            fetch_pc_q   <= START_ADDR;
            ask_q        <= 1'b0;
            addr_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_valid_q <= 1'b0;
            head_inst_q  <= '0;
            head_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            ask_q        <= ask_d;
            addr_q       <= addr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_valid_q <= head_valid_d;
            head_inst_q  <= head_inst_d;
            head_pc_q    <= head_pc_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && push) begin
            mem_inst_q[wr_ptr_q] <= MC_IF_Inst;
            mem_pc_q[wr_ptr_q]   <= fetch_pc_q;
        end
    end

    assign IF_MC_ask   = ask_q;
    assign IF_MC_Addr  = addr_q;
    assign IF_ID_valid = head_valid_q;
    assign IF_ID_Inst  = head_inst_q;
    assign IF_ID_PC    = head_pc_q;

endmodule
